// File: rtl/logic_exec_stage.sv
// Registered execute stage for the logical ALU ops (XOR/AND/OR/NOR).
// Results are queued in a 2-entry FIFO so writeback back-pressure never drops one.
module logic_exec_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic [1:0]       out_count
);

  logic [WIDTH-1:0] res;
  logic             zero;
  logic             push;
  logic             pop;

  // Each entry stores {zero, result}.
  logic [WIDTH:0]   mem_q [0:1];
  logic             rd_ptr_q;
  logic             wr_ptr_q;
  logic [1:0]       count_q;

  always_comb begin
    res = '0;
    unique case (in_op)
      2'b00:   res = in_a ^ in_b;
      2'b01:   res = in_a & in_b;
      2'b10:   res = in_a | in_b;
      default: res = ~(in_a | in_b);
    endcase
  end

  assign zero = ~|res;

  // Handshake flags depend only on registered occupancy, never on out_ready.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_result = mem_q[rd_ptr_q][WIDTH-1:0];
  assign out_zero   = mem_q[rd_ptr_q][WIDTH];
  assign out_count  = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      // Flush wins over any same-cycle push or pop.
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {zero, res};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_exec_stage.sv
// Scoreboard bench for logic_exec_stage: driver records expected results on
// accepted transfers, an independent monitor checks every popped result.
module tb_logic_exec_stage;

  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic [1:0]       out_count;

  logic [WIDTH:0]   exp_q [$];
  int               checks;
  int               failures;
  logic             last_push;

  logic_exec_stage #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_count  (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: logical function chosen by op, zero flag from the full result.
  function automatic logic [WIDTH:0] model(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      2'd0:    r = a ^ b;
      2'd1:    r = a & b;
      2'd2:    r = a | b;
      default: r = ~(a | b);
    endcase
    return {(r == '0), r};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: occupancy every cycle, result/zero on every pop.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (out_count !== 2'(exp_q.size()) || out_valid !== (exp_q.size() != 0) ||
          in_ready !== (exp_q.size() != 2)) begin
        failures++;
        $display("FAIL occupancy: count=%0d valid=%b ready=%b expected entries=%0d",
                 out_count, out_valid, in_ready, exp_q.size());
      end
      if (out_valid === 1'b1 && out_ready && !flush && exp_q.size() != 0) begin
        logic [WIDTH:0] e;
        e = exp_q.pop_front();
        checks++;
        if (out_result !== e[WIDTH-1:0] || out_zero !== e[WIDTH]) begin
          failures++;
          $display("FAIL result: got %h zero=%b expected %h zero=%b",
                   out_result, out_zero, e[WIDTH-1:0], e[WIDTH]);
        end
      end
    end
  end

  // One clock: record the transfer (after the monitor's sample), then move past the edge.
  task automatic tick();
    @(negedge clk);
    #1;
    last_push = 1'b0;
    if (rst_n && flush) begin
      exp_q.delete();
    end else if (rst_n && in_valid && in_ready) begin
      exp_q.push_back(model(in_op, in_a, in_b));
      last_push = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
  endtask

  task automatic wait_acc(input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_push && n < 50);
    chk({name, "_accept"}, 64'(last_push), 64'd1);
    in_valid = 1'b0;
    in_op    = 2'($urandom);
    in_a     = $urandom;
    in_b     = $urandom;
  endtask

  task automatic send(input logic [1:0] op, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, input string name);
    drive(op, a, b);
    wait_acc(name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks    = 0;
    failures  = 0;
    last_push = 1'b0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 2'd0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    #23;
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_ready", 64'(in_ready), 64'd1);
    chk("reset_result", 64'(out_result), 64'd0);
    chk("reset_zero", 64'(out_zero), 64'd0);
    chk("reset_count", 64'(out_count), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: single XOR, visible one cycle after acceptance.
    send(2'd0, 32'hFFFF_FFFF, 32'h0000_0000, "t1");
    chk("t1_latency_valid", 64'(out_valid), 64'd1);
    chk("t1_result", 64'(out_result), 64'hFFFF_FFFF);
    chk("t1_zero", 64'(out_zero), 64'd0);
    tick();
    chk("t1_drained", 64'(out_count), 64'd0);

    // 2: zero flag set and clear.
    send(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "t2a");
    send(2'd0, 32'h0000_0000, 32'h007F_A509, "t2b");
    repeat (3) tick();

    // 3: back-pressure, third op stalls until a slot frees.
    out_ready = 1'b0;
    send(2'd1, 32'hF0F0_F0F0, 32'hFF00_FF00, "t3_and");
    send(2'd2, 32'h0000_0000, 32'h0000_0001, "t3_or");
    drive(2'd3, 32'h0000_0000, 32'h0000_0000);
    repeat (3) begin
      tick();
      chk("t3_stall", 64'(last_push), 64'd0);
      chk("t3_ready_low", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    wait_acc("t3_nor");
    repeat (4) tick();

    // 4: steady count=1 with push and pop every cycle.
    out_ready = 1'b0;
    send(2'($urandom), $urandom, $urandom, "t4_fill");
    out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      drive(2'($urandom), $urandom, $urandom);
      tick();
      if (!last_push) begin
        chk("t4_push", 64'(last_push), 64'd1);
      end
    end
    chk("t4_count", 64'(out_count), 64'd1);
    in_valid = 1'b0;
    repeat (3) tick();

    // 5: flush with a full buffer and a pending push.
    out_ready = 1'b0;
    send(2'd2, 32'h1234_5678, 32'h0, "t5a");
    send(2'd1, 32'hFFFF_0000, 32'h0F0F_0F0F, "t5b");
    drive(2'd0, 32'hAAAA_AAAA, 32'h5555_5555);
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("t5_count", 64'(out_count), 64'd0);
    chk("t5_valid", 64'(out_valid), 64'd0);
    chk("t5_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (3) tick();

    // 6: asynchronous reset with two entries held.
    out_ready = 1'b0;
    send(2'd3, 32'h0, 32'h0, "t6a");
    send(2'd2, 32'hDEAD_0000, 32'h0000_BEEF, "t6b");
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_valid", 64'(out_valid), 64'd0);
    chk("t6_ready", 64'(in_ready), 64'd1);
    chk("t6_result", 64'(out_result), 64'd0);
    chk("t6_count", 64'(out_count), 64'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(2'd0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, "t6_resume");

    // Random mixed traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_op     = 2'($urandom);
      in_a      = ($urandom_range(0, 7) == 0) ? in_b : $urandom;
      in_b      = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      tick();
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    chk("final_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
